// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between NREQ requesters,
// with a lock for multi-beat ownership and a lock timeout that forcibly frees the port.
module mem_port_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               lock_err_o,
    output logic [AW-1:0]      mem_addr_o,
    output logic [DW-1:0]      mem_wdata_o,
    output logic               mem_wr_o,
    input  logic [DW-1:0]      mem_rdata_i
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [0:0] {StFree, StOwned} state_e;

    state_e          state_q, state_d;
    idx_t            ptr_q, ptr_d;
    idx_t            owner_q, owner_d;
    idx_t            sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lock_err_q, lock_err_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    logic [NREQ-1:0] gnt;
    idx_t            gidx;
    logic            gvalid;
    idx_t            mux_idx;
    int              cand;

    function automatic idx_t inc_wrap(input idx_t i);
        return (i == idx_t'(NREQ - 1)) ? '0 : i + idx_t'(1);
    endfunction

    // Grant: owner-only while locked, otherwise first requester scanning from ptr.
    always_comb begin
        gnt    = '0;
        gidx   = '0;
        gvalid = 1'b0;
        cand   = 0;
        if (state_q == StOwned) begin
            if (req_i[owner_q]) begin
                gvalid = 1'b1;
                gidx   = owner_q;
            end
        end else begin
            for (int k = 0; k < int'(NREQ); k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= int'(NREQ)) begin
                    cand = cand - int'(NREQ);
                end
                if (!gvalid && req_i[idx_t'(cand)]) begin
                    gvalid = 1'b1;
                    gidx   = idx_t'(cand);
                end
            end
        end
        // Nothing may reach the memory while reset is asserted.
        if (!rst_n) begin
            gvalid = 1'b0;
        end
        if (gvalid) begin
            gnt[gidx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFree;
            ptr_q      <= '0;
            owner_q    <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
        sel_d      = gvalid ? gidx : sel_q;
        rvalid_d   = (gvalid && !we_i[gidx]) ? gnt : '0;
        unique case (state_q)
            StFree: begin
                if (gvalid) begin
                    if (lock_i[gidx]) begin
                        state_d = StOwned;
                        owner_d = gidx;
                        cnt_d   = CW'(1);
                    end else begin
                        ptr_d = inc_wrap(gidx);
                    end
                end
            end
            StOwned: begin
                if (gvalid && !lock_i[owner_q]) begin
                    state_d = StFree;
                    cnt_d   = '0;
                    ptr_d   = inc_wrap(owner_q);
                end else if (cnt_q >= CW'(LOCK_MAX)) begin
                    // Forced release; a beat taken in this cycle still advances the pointer.
                    state_d    = StFree;
                    cnt_d      = '0;
                    lock_err_d = 1'b1;
                    if (gvalid) begin
                        ptr_d = inc_wrap(owner_q);
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StFree;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        mux_idx     = gvalid ? gidx : sel_q;
        gnt_o       = gnt;
        rvalid_o    = rvalid_q;
        rdata_o     = mem_rdata_i;
        lock_err_o  = lock_err_q;
        mem_addr_o  = addr_i[mux_idx*AW +: AW];
        mem_wdata_o = wdata_i[mux_idx*DW +: DW];
        mem_wr_o    = gvalid & we_i[gidx];
    end

endmodule
